keypad_scanner: RTL
===================

// Module: keypad_scanner
// PURPOSE
//  Scans a 4x4 matrix keypad and emits one debounced 4-bit key code per press.
//  Key codes follow the calculator convention:
//    - 0..9 = digits
//    - A=1010, B=1011 (-), C=1100 (+), D=1101 (=), #=1110 (getM), *=1111 (setM)
//  Output feeds the control decoder's key field. key_valid strobes the calculator state register.
// PARAMETERS
//  CLK_DIV         1000  clk cycles per scan tick; minimum 2
//  DEBOUNCE_TICKS  8     consecutive identical tick samples required for press/release; minimum 1
//  REPEAT_TICKS    250   ticks between auto-repeat strobes; used only with KEY_REPEAT_EN
// PORTS
//  clk        in   1  system clock
//  rst_n      in   1  synchronous reset, active-low
//  row        in   4  keypad rows; active-low, externally pulled up; asynchronous
//  col        out  4  column drive; active-low; exactly one bit low at all times
//  key        out  4  code of the last accepted key; stable until the next accept
//  key_valid  out  1  1-cycle strobe; key is valid in the same cycle
//  key_held   out  1  high while the accepted key stays pressed
// BEHAVIOUR
//  - Reset values (synchronous, rst_n=0 at a clk edge):
//    - col=4'b1110, key=4'b0000, key_valid=0, key_held=0
//    - state=SCAN, prescaler=0, deb_cnt=0, synchroniser flops=4'b1111
//    - Reset mid-operation aborts any debounce or press; no strobe is produced.
//  - Rows pass through a 2-flop synchroniser (rs). All decisions use rs, sampled only on tick.
//  - tick: prescaler counts 0..CLK_DIV-1 and wraps. tick=1 in the cycle where prescaler==CLK_DIV-1.
//  - Key map (row r, col c; c0 = col[0] low):
//    - r0: 1 2 3 A
//    - r1: 4 5 6 B
//    - r2: 7 8 9 C
//    - r3: * 0 # D
//  - Valid press pattern: rs has exactly one bit low. Zero low = idle. Two or more low = invalid, treated as idle.
//  - FSM (all transitions only on tick):
//    - SCAN:
//      - valid pattern -> latch (c, r), deb_cnt=1, go to DEBOUNCE; col holds.
//      - otherwise -> rotate col 1110->1101->1011->0111->1110 (one tick of settling before the next sample).
//    - DEBOUNCE:
//      - pattern equals latched r -> deb_cnt++.
//      - pattern differs -> deb_cnt=0, go to SCAN; col is not advanced on this tick.
//      - deb_cnt reaching DEBOUNCE_TICKS (including immediately when DEBOUNCE_TICKS=1) -> in the next clk cycle:
//        key=code(c,r), key_valid=1 for exactly that cycle, key_held=1, go to PRESSED.
//    - PRESSED:
//      - col holds.
//      - rs==4'b1111 -> deb_cnt++; any low row -> deb_cnt=0.
//      - deb_cnt reaching DEBOUNCE_TICKS -> key_held=0, deb_cnt=0, go to SCAN.
//      - A second key pressed while held is ignored until release. Key rollover is not supported.
//  - Latency: key_valid asserts 1 clk after the DEBOUNCE_TICKS-th matching tick.
//    Total latency from press to key_valid is at most (4+DEBOUNCE_TICKS)*CLK_DIV + 3 clk.
//  - key_valid and key_held never assert outside a debounced press.
//  - key is never changed except together with key_valid.
// CONFIGURATION
//  - KEY_REPEAT_EN defined:
//    - In PRESSED, a repeat counter counts ticks while the key stays held; it is cleared on entry.
//    - Every REPEAT_TICKS ticks, key_valid pulses again for 1 cycle with an unchanged key.
//  - KEY_REPEAT_EN undefined:
//    - No repeat counter is present. Exactly one key_valid per press.
// TESTING (bench: CLK_DIV=4, DEBOUNCE_TICKS=3, REPEAT_TICKS=5)
//  1. Reset: hold rst_n=0 for 2 clk -> col=1110, key=0000, key_valid=0, key_held=0; col rotates every 4 clk afterwards.
//  2. Press '5' (row1 low when col1 low), hold 60 clk, release -> one key_valid, key=0101, key_held high until ~3 ticks after release.
//  3. Press 'C' pulses for 2 ticks only (shorter than debounce) -> no key_valid, FSM returns to SCAN, key unchanged.
//  4. Rows 0 and 2 low together on col0 -> no key_valid; col keeps rotating.
//  5. Press '#' (row3/col2) -> key=1110. Release, then press '*' (row3/col0) -> key=1111. Exactly two strobes.
//  6. Assert rst_n=0 mid-DEBOUNCE of '9' -> no strobe, col=1110; after release and re-press '9', key=1001 strobes once.
//  7. KEY_REPEAT_EN defined: hold '0' for 20 ticks -> first strobe, then strobes every 5 ticks, all with key=0000.

Source files
------------

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low keypad and emits one debounced key code per press.
// Optional auto-repeat while a key is held is enabled by defining KEY_REPEAT_EN.
module keypad_scanner #(
    parameter int unsigned CLK_DIV        = 1000,
    parameter int unsigned DEBOUNCE_TICKS = 8,
    parameter int unsigned REPEAT_TICKS   = 250
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key,
    output logic       key_valid,
    output logic       key_held
);

    localparam int unsigned PW = $clog2(CLK_DIV);
    localparam int unsigned DW = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_TICKS - 1);

    if (CLK_DIV < 2 || DEBOUNCE_TICKS < 1 || REPEAT_TICKS < 1) begin : g_bad_cfg
        $error("keypad_scanner: CLK_DIV>=2, DEBOUNCE_TICKS>=1 and REPEAT_TICKS>=1 required");
    end

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        PRESSED
    } state_t;

    state_t        state, state_nx;
    logic [PW-1:0] prescaler;
    logic          tick;
    logic [3:0]    rs_meta, rs;
    logic [1:0]    col_idx, col_idx_nx;
    logic [1:0]    row_lat, row_lat_nx;
    logic [DW-1:0] deb_cnt, deb_nx;
    logic [3:0]    key_nx;
    logic          valid_nx, held_nx;
    logic          row_ok;
    logic [1:0]    row_idx;
    logic          accept;

`ifdef KEY_REPEAT_EN
    localparam int unsigned RW = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_TICKS - 1);
    logic [RW-1:0] rep_cnt, rep_nx;
`endif

    function automatic logic one_low(input logic [3:0] r);
        logic [3:0] a;
        a = ~r;
        return (a != 4'b0000) && ((a & (a - 4'd1)) == 4'b0000);
    endfunction

    function automatic logic [1:0] low_idx(input logic [3:0] r);
        case (r)
            4'b1101: return 2'd1;
            4'b1011: return 2'd2;
            4'b0111: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [3:0] keycode(input logic [1:0] c, input logic [1:0] r);
        case ({r, c})
            4'b00_00: return 4'h1;
            4'b00_01: return 4'h2;
            4'b00_10: return 4'h3;
            4'b00_11: return 4'hA;
            4'b01_00: return 4'h4;
            4'b01_01: return 4'h5;
            4'b01_10: return 4'h6;
            4'b01_11: return 4'hB;
            4'b10_00: return 4'h7;
            4'b10_01: return 4'h8;
            4'b10_10: return 4'h9;
            4'b10_11: return 4'hC;
            4'b11_00: return 4'hF;
            4'b11_01: return 4'h0;
            4'b11_10: return 4'hE;
            default:  return 4'hD;
        endcase
    endfunction

    assign tick    = (prescaler == PRE_LAST);
    assign row_ok  = one_low(rs);
    assign row_idx = low_idx(rs);
    assign col     = ~(4'b0001 << col_idx);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prescaler <= '0;
            rs_meta   <= '1;
            rs        <= '1;
        end else begin
            prescaler <= tick ? '0 : prescaler + 1'b1;
            rs_meta   <= row;
            rs        <= rs_meta;
        end
    end

    always_comb begin
        state_nx   = state;
        col_idx_nx = col_idx;
        row_lat_nx = row_lat;
        deb_nx     = deb_cnt;
        key_nx     = key;
        valid_nx   = 1'b0;
        held_nx    = key_held;
        accept     = 1'b0;
`ifdef KEY_REPEAT_EN
        rep_nx     = rep_cnt;
`endif
        if (tick) begin
            case (state)
                SCAN: begin
                    if (row_ok) begin
                        row_lat_nx = row_idx;
                        deb_nx     = DW'(1);
                        state_nx   = DEBOUNCE;
                        accept     = (DEBOUNCE_TICKS == 1);
                    end else begin
                        col_idx_nx = col_idx + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (row_ok && row_idx == row_lat) begin
                        deb_nx = deb_cnt + 1'b1;
                        accept = (deb_cnt == DEB_LAST);
                    end else begin
                        deb_nx   = '0;
                        state_nx = SCAN;
                    end
                end
                PRESSED: begin
                    if (rs == 4'b1111) begin
                        if (deb_cnt == DEB_LAST) begin
                            deb_nx   = '0;
                            held_nx  = 1'b0;
                            state_nx = SCAN;
                        end else begin
                            deb_nx = deb_cnt + 1'b1;
                        end
                    end else begin
                        deb_nx = '0;
`ifdef KEY_REPEAT_EN
                        // Repeat only advances while the row still reads pressed.
                        if (rep_cnt == REP_LAST) begin
                            rep_nx   = '0;
                            valid_nx = 1'b1;
                        end else begin
                            rep_nx = rep_cnt + 1'b1;
                        end
`endif
                    end
                end
                default: state_nx = SCAN;
            endcase
            // SCAN latches row_lat this tick, so the accepted row comes from rs when DEBOUNCE_TICKS==1.
            if (accept) begin
                key_nx   = keycode(col_idx, (state == SCAN) ? row_idx : row_lat);
                valid_nx = 1'b1;
                held_nx  = 1'b1;
                deb_nx   = '0;
                state_nx = PRESSED;
`ifdef KEY_REPEAT_EN
                rep_nx   = '0;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= SCAN;
            col_idx   <= '0;
            row_lat   <= '0;
            deb_cnt   <= '0;
            key       <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
`ifdef KEY_REPEAT_EN
            rep_cnt   <= '0;
`endif
        end else begin
            state     <= state_nx;
            col_idx   <= col_idx_nx;
            row_lat   <= row_lat_nx;
            deb_cnt   <= deb_nx;
            key       <= key_nx;
            key_valid <= valid_nx;
            key_held  <= held_nx;
`ifdef KEY_REPEAT_EN
            rep_cnt   <= rep_nx;
`endif
        end
    end

endmodule
